// File: rtl/systolic_mm_pkg.sv
// Shared types and helpers for the output-stationary systolic matrix multiplier.
package systolic_mm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Clip a sign/zero-extended accumulator value into a res_w-bit signed or
  // unsigned range; clip reports whether the value had to be limited.
  function automatic logic signed [63:0] sat_narrow(
    input  logic signed [63:0] v,
    input  int unsigned        res_w,
    input  logic               sgn,
    output logic               clip
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    if (sgn) begin
      hi = (64'sd1 <<< (res_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (res_w - 1));
    end else begin
      hi = (64'sd1 <<< res_w) - 64'sd1;
      lo = '0;
    end
    clip = 1'b0;
    r    = v;
    if (v > hi) begin
      r    = hi;
      clip = 1'b1;
    end else if (v < lo) begin
      r    = lo;
      clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_mm_stream_mac_pe.sv
// Single processing element: forwards a/b to its neighbours through registers
// and accumulates a*b in place (output-stationary).
module mac_pe
  import systolic_mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  sgn,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int unsigned PW = 2 * DATA_WIDTH + 2;

  logic [DATA_WIDTH-1:0]  a_q, a_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH:0] a_x, b_x;
  logic signed [PW-1:0]   prod;

  // One extra top bit makes a single signed multiplier serve both modes.
  always_comb begin
    a_x  = $signed({sgn & a_in[DATA_WIDTH-1], a_in});
    b_x  = $signed({sgn & b_in[DATA_WIDTH-1], b_in});
    prod = PW'(a_x) * PW'(b_x);
  end

  // Next passthrough and accumulator values; clear has priority over enable.
  always_comb begin
    a_d   = a_in;
    b_d   = b_in;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  // Register operand pipes and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_stream.sv
// Output-stationary MxP systolic array computing C = A*B or C += A*B per job,
// with valid/ready handshakes and saturating result narrowing.
module systolic_mm_stream
  import systolic_mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned RES_WIDTH  = 16,
  parameter int unsigned M          = 4,
  parameter int unsigned N          = 4,
  parameter int unsigned P          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_acc,
  input  logic                        in_signed,
  input  logic [M*N*DATA_WIDTH-1:0]   matrix_a,
  input  logic [N*P*DATA_WIDTH-1:0]   matrix_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [M*P*RES_WIDTH-1:0]    result_c,
  output logic                        overflow
);

  localparam int unsigned STEPS = M + N + P;
  localparam int unsigned CNT_W = clog2(STEPS);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(STEPS - 3);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          t_q, t_d;
  logic [M*N*DATA_WIDTH-1:0] a_q, a_d;
  logic [N*P*DATA_WIDTH-1:0] b_q, b_d;
  logic                      sgn_q, sgn_d;
  logic [M*P*RES_WIDTH-1:0]  res_q, res_d;
  logic                      ovf_q, ovf_d;

  logic accept;
  logic pe_clr;
  logic pe_en;

  logic [DATA_WIDTH-1:0] a_inj [M];
  logic [DATA_WIDTH-1:0] b_inj [P];
  logic [DATA_WIDTH-1:0] a_h   [M][P];
  logic [DATA_WIDTH-1:0] b_v   [M][P];
  logic [DATA_WIDTH-1:0] a_edge_unused [M];
  logic [DATA_WIDTH-1:0] b_edge_unused [P];
  logic [ACC_WIDTH-1:0]  acc_w [M][P];

  assign accept    = in_valid && (state_q == IDLE);
  assign pe_clr    = accept && !in_acc;
  assign pe_en     = (state_q == FEED);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign result_c  = res_q;
  assign overflow  = ovf_q;

  // Job sequencing: accept latches operands, FEED counts skew steps.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FEED;
          t_d     = '0;
          a_d     = matrix_a;
          b_d     = matrix_b;
          sgn_d   = in_signed;
        end
      end
      FEED: begin
        if (t_q == T_LAST) begin
          state_d = FLUSH;
          t_d     = '0;
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      FLUSH:   state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Skew muxes: row i carries a(i,k) at t=k+i, column j carries b(k,j) at t=k+j.
  always_comb begin
    for (int unsigned i = 0; i < M; i++) begin
      a_inj[i] = '0;
      for (int unsigned k = 0; k < N; k++) begin
        if (pe_en && (32'(t_q) == i + k)) a_inj[i] = a_q[(i*N+k)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int unsigned j = 0; j < P; j++) begin
      b_inj[j] = '0;
      for (int unsigned k = 0; k < N; k++) begin
        if (pe_en && (32'(t_q) == j + k)) b_inj[j] = b_q[(k*P+j)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Narrow every accumulator in FLUSH; results hold otherwise.
  always_comb begin
    logic clip;
    clip  = 1'b0;
    res_d = res_q;
    ovf_d = ovf_q;
    if (state_q == FLUSH) begin
      ovf_d = 1'b0;
      for (int unsigned i = 0; i < M; i++) begin
        for (int unsigned j = 0; j < P; j++) begin
          res_d[(i*P+j)*RES_WIDTH +: RES_WIDTH] = RES_WIDTH'(sat_narrow(
            sgn_q ? 64'($signed(acc_w[i][j])) : 64'(acc_w[i][j]), RES_WIDTH, sgn_q, clip));
          ovf_d = ovf_d | clip;
        end
      end
    end
  end

  // Control, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_a_inj
    assign a_h[i][0] = a_inj[i];
  end
  for (genvar j = 0; j < P; j++) begin : g_b_inj
    assign b_v[0][j] = b_inj[j];
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < P; j++) begin : g_pe
      logic [DATA_WIDTH-1:0] a_out_w;
      logic [DATA_WIDTH-1:0] b_out_w;

      mac_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (pe_clr),
        .en   (pe_en),
        .sgn  (sgn_q),
        .a_in (a_h[i][j]),
        .b_in (b_v[i][j]),
        .a_out(a_out_w),
        .b_out(b_out_w),
        .acc  (acc_w[i][j])
      );

      // Operands leaving the array edge have no consumer.
      if (j < P - 1) begin : g_a_pass
        assign a_h[i][j+1] = a_out_w;
      end else begin : g_a_edge
        assign a_edge_unused[i] = a_out_w;
      end
      if (i < M - 1) begin : g_b_pass
        assign b_v[i+1][j] = b_out_w;
      end else begin : g_b_edge
        assign b_edge_unused[j] = b_out_w;
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_stream.sv
// Self-checking bench for systolic_mm_stream: directed cases plus randomized
// jobs checked against a plain-arithmetic matrix model.
module tb_systolic_mm_stream;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int RW = 16;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int P  = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_acc = 1'b0;
  logic                 in_signed = 1'b0;
  logic [M*N*DW-1:0]    matrix_a = '0;
  logic [N*P*DW-1:0]    matrix_b = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [M*P*RW-1:0]    result_c;
  logic                 overflow;

  always #5 clk = ~clk;

  systolic_mm_stream #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .RES_WIDTH (RW),
    .M         (M),
    .N         (N),
    .P         (P)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_acc   (in_acc),
    .in_signed(in_signed),
    .matrix_a (matrix_a),
    .matrix_b (matrix_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result_c (result_c),
    .overflow (overflow)
  );

  int tests = 0;
  int fails = 0;

  // Model state: accumulator bit patterns and expected outputs of the current job.
  longint            acc_m [M][P];
  logic [M*P*RW-1:0] exp_flat = '0;
  logic              exp_ovf  = 1'b0;

  task automatic check(input string name, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_vec(input string name, input logic [M*P*RW-1:0] got,
                           input logic [M*P*RW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  function automatic longint elem(input logic [DW-1:0] x, input logic sgn);
    longint v;
    v = longint'(x);
    if (sgn && x[DW-1]) v = v - (longint'(1) << DW);
    return v;
  endfunction

  // C(i,j) = sum_k a(i,k)*b(k,j), added to previous C when acc, wrapped to AW bits,
  // then clipped to the RW-bit range of the job's signedness.
  task automatic model_job(input logic [M*N*DW-1:0] a, input logic [N*P*DW-1:0] b,
                           input logic acc, input logic sgn);
    longint s, v, hi, lo;
    logic   o;
    o  = 1'b0;
    hi = sgn ? (longint'(1) << (RW - 1)) - 1 : (longint'(1) << RW) - 1;
    lo = sgn ? -(longint'(1) << (RW - 1)) : 0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < P; j++) begin
        s = acc ? acc_m[i][j] : 0;
        for (int k = 0; k < N; k++)
          s += elem(a[(i*N+k)*DW +: DW], sgn) * elem(b[(k*P+j)*DW +: DW], sgn);
        s = s & ((longint'(1) << AW) - 1);
        acc_m[i][j] = s;
        v = s;
        if (sgn && v >= (longint'(1) << (AW - 1))) v = v - (longint'(1) << AW);
        if (v > hi) begin v = hi; o = 1'b1; end
        else if (v < lo) begin v = lo; o = 1'b1; end
        exp_flat[(i*P+j)*RW +: RW] = v[RW-1:0];
      end
    end
    exp_ovf = o;
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) acc_m[i][j] = 0;
    exp_flat = '0;
    exp_ovf  = 1'b0;
  endtask

  // Whenever a result is presented it must match the model and stay put.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check_vec("hold_result", result_c, exp_flat);
      check("hold_overflow", longint'(overflow), longint'(exp_ovf));
      check("hold_in_ready", longint'(in_ready), 0);
    end
  end

  task automatic check_elem(input string name, input int i, input int j,
                            input logic sgn, input longint want);
    logic [RW-1:0] r;
    longint        got;
    r   = result_c[(i*P+j)*RW +: RW];
    got = longint'(r);
    if (sgn && r[RW-1]) got = got - (longint'(1) << RW);
    check($sformatf("%s(%0d,%0d)", name, i, j), got, want);
  endtask

  // Offer one job, measure latency, optionally stall the consumer, then drain.
  // Latency is the number of clock edges from the accept edge to the first edge
  // at which out_valid is sampled high.
  task automatic run_job(input logic [M*N*DW-1:0] a, input logic [N*P*DW-1:0] b,
                         input logic acc, input logic sgn, input int hold, input logic poke);
    int e;
    @(negedge clk);
    matrix_a  = a;
    matrix_b  = b;
    in_acc    = acc;
    in_signed = sgn;
    in_valid  = 1'b1;
    e = 0;
    while (!in_ready && e < 20) begin
      @(negedge clk);
      e++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    model_job(a, b, acc, sgn);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    matrix_a  = ~a;
    matrix_b  = ~b;
    in_acc    = ~acc;
    in_signed = ~sgn;
    @(negedge clk);
    e = 0;
    while (!out_valid && e < 40) begin
      @(negedge clk);
      e++;
    end
    check("latency", e + 1, M + N + P);
    if (!out_valid) return;
    for (int c = 0; c < hold; c++) begin
      if (poke) begin
        in_valid = 1'b1;
        matrix_a = {4{$urandom}};
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_in_ready", longint'(in_ready), 1);
    check("post_out_valid", longint'(out_valid), 0);
    check_vec("post_result", result_c, exp_flat);
  endtask

  function automatic logic [M*N*DW-1:0] mat_ident();
    logic [M*N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) r[(i*N+i)*DW +: DW] = DW'(1);
    return r;
  endfunction

  function automatic logic [N*P*DW-1:0] mat_seq();
    logic [N*P*DW-1:0] r;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < P; j++) r[(k*P+j)*DW +: DW] = DW'(4 * k + j + 1);
    return r;
  endfunction

  function automatic logic [M*N*DW-1:0] mat_fill(input logic [DW-1:0] v);
    logic [M*N*DW-1:0] r;
    for (int e = 0; e < M * N; e++) r[e*DW +: DW] = v;
    return r;
  endfunction

  task automatic check_t1(input string name, input longint scale);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) check_elem(name, i, j, 1'b1, scale * (4 * i + j + 1));
    check({name, "_ovf"}, longint'(overflow), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    logic [M*N*DW-1:0] ra;
    logic [N*P*DW-1:0] rb;
    int                mode;

    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_overflow", longint'(overflow), 0);
    check_vec("reset_result", result_c, '0);

    // T1 identity
    run_job(mat_ident(), mat_seq(), 1'b0, 1'b1, 2, 1'b0);
    check_t1("t1_c", 1);
    check("model_pin_t1", longint'(exp_flat[RW-1:0]), 1);

    // T2 signed saturation
    run_job(mat_fill(8'd127), mat_fill(8'd127), 1'b0, 1'b1, 1, 1'b0);
    check("model_pin_t2a", longint'(exp_flat[RW-1:0]), 32767);
    for (int i = 0; i < M; i++) check_elem("t2a_c", i, i, 1'b1, 32767);
    check("t2a_ovf", longint'(overflow), 1);
    run_job(mat_fill(8'h80), mat_fill(8'd127), 1'b0, 1'b1, 0, 1'b0);
    for (int j = 0; j < P; j++) check_elem("t2b_c", 0, j, 1'b1, -32768);
    check("t2b_ovf", longint'(overflow), 1);

    // T3 unsigned
    run_job(mat_fill(8'hff), mat_fill(8'hff), 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < M; i++) check_elem("t3a_c", i, P - 1 - i, 1'b0, 65535);
    check("t3a_ovf", longint'(overflow), 1);
    run_job(mat_fill(8'd16), mat_fill(8'd16), 1'b0, 1'b0, 1, 1'b0);
    check("model_pin_t3b", longint'(exp_flat[RW-1:0]), 1024);
    for (int j = 0; j < P; j++) check_elem("t3b_c", M - 1, j, 1'b0, 1024);
    check("t3b_ovf", longint'(overflow), 0);

    // T4 accumulate
    run_job(mat_ident(), mat_seq(), 1'b0, 1'b1, 0, 1'b0);
    check_t1("t4a_c", 1);
    run_job(mat_ident(), mat_seq(), 1'b1, 1'b1, 0, 1'b0);
    check_t1("t4b_c", 2);
    run_job(mat_ident(), mat_seq(), 1'b0, 1'b1, 0, 1'b0);
    check_t1("t4c_c", 1);

    // T5 backpressure with extra offers while held
    run_job(mat_ident(), mat_seq(), 1'b1, 1'b1, 20, 1'b1);
    check_t1("t5_c", 2);

    // T6 reset during FEED at t=5
    @(negedge clk);
    matrix_a  = mat_ident();
    matrix_b  = mat_seq();
    in_acc    = 1'b1;
    in_signed = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("t6_in_ready", longint'(in_ready), 1);
    check("t6_out_valid", longint'(out_valid), 0);
    check("t6_overflow", longint'(overflow), 0);
    check_vec("t6_result", result_c, '0);
    run_job(mat_ident(), mat_seq(), 1'b1, 1'b1, 0, 1'b0);
    check_t1("t6_c", 1);

    // Randomized jobs
    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 3));
      for (int e = 0; e < M * N; e++) begin
        case (mode)
          0:       ra[e*DW +: DW] = DW'($urandom);
          1:       ra[e*DW +: DW] = $urandom_range(0, 1) != 0 ? 8'h7f : 8'h80;
          2:       ra[e*DW +: DW] = 8'hff;
          default: ra[e*DW +: DW] = DW'($urandom_range(0, 20));
        endcase
      end
      for (int e = 0; e < N * P; e++) begin
        case (mode)
          0:       rb[e*DW +: DW] = DW'($urandom);
          1:       rb[e*DW +: DW] = $urandom_range(0, 1) != 0 ? 8'h7f : 8'h80;
          2:       rb[e*DW +: DW] = DW'($urandom);
          default: rb[e*DW +: DW] = DW'($urandom_range(0, 20));
        endcase
      end
      run_job(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
